// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART types, parity encodings and baud divider helper.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Clocks per oversample tick, never below one.
    function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
        int d;
        d = clk_hz / (baud * oversample);
        return (d < 1) ? 1 : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_tick
// Brief    : Oversample tick generator, one-cycle tick every DIV clocks.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic r_clk,
    input  logic r_rst_n,
    input  logic clear,
    output logic tick
);

    localparam int                 c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_cnt <= '0;
        end else if (clear || (r_cnt == c_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    assign tick = !clear && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_param
// Brief    : Oversampling UART receiver with valid/ready output and error
//            status. Optional break detection via UART_RX_BREAK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int BAUD        = 115_200,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1
) (
    input  logic                 r_clk,
    input  logic                 r_rst_n,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
`ifdef UART_RX_BREAK_EN
    ,
    output logic                 break_det
`endif
);

    localparam int                 c_div       = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int                 c_os_w      = $clog2(OVERSAMPLE);
    localparam logic [c_os_w-1:0]  c_os_mid    = c_os_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_os_w-1:0]  c_os_last   = c_os_w'(OVERSAMPLE - 1);
    localparam int                 c_bit_w     = $clog2(DATA_BITS + 1);
    localparam logic [c_bit_w-1:0] c_data_last = c_bit_w'(DATA_BITS - 1);
    localparam logic [c_bit_w-1:0] c_stop_last = c_bit_w'(STOP_BITS - 1);
`ifdef UART_RX_BREAK_EN
    localparam bit                 c_brk_en    = 1'b1;
`else
    localparam bit                 c_brk_en    = 1'b0;
`endif

    logic                 r_sync1;
    logic                 r_sync2;
    uart_rx_state_t       r_state;
    uart_rx_state_t       w_state_nxt;
    logic [c_os_w-1:0]    r_os_cnt;
    logic [c_bit_w-1:0]   r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic                 r_frm_err;
    logic                 r_zero;
    logic                 r_brk_hold;
    logic                 w_tick;
    logic                 w_sample;
    logic                 w_deliver;
    logic                 w_word_frm;
    logic                 w_word_brk;
    logic                 w_brk_now;
    logic                 w_par_exp;

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
        end
    end

    uart_baud_tick #(
        .DIV     (c_div)
    ) u_baud_tick (
        .r_clk   (r_clk),
        .r_rst_n (r_rst_n),
        .clear   (r_state == ST_IDLE),
        .tick    (w_tick)
    );

    assign w_par_exp = (PARITY_MODE == PAR_ODD) ? ~^r_shift : ^r_shift;
    // Break: all-zero data/parity and a low first stop bit.
    assign w_brk_now = c_brk_en && (r_bit_cnt == '0) && r_zero && !r_sync2;

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sample    = 1'b0;
        w_deliver   = 1'b0;
        w_word_frm  = r_frm_err;
        w_word_brk  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_sync2) w_state_nxt = ST_START;
            end
            ST_START: begin
                if (w_tick && (r_os_cnt == c_os_mid)) begin
                    w_sample    = 1'b1;
                    w_state_nxt = r_sync2 ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick && (r_os_cnt == c_os_last)) begin
                    w_sample = 1'b1;
                    if (r_bit_cnt == c_data_last) begin
                        w_state_nxt = (PARITY_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick && (r_os_cnt == c_os_last)) begin
                    w_sample    = 1'b1;
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (r_brk_hold) begin
                    if (r_sync2) w_state_nxt = ST_IDLE;
                end else if (w_tick && (r_os_cnt == c_os_last)) begin
                    w_sample   = 1'b1;
                    w_word_frm = r_frm_err | !r_sync2;
                    if (w_brk_now) begin
                        w_deliver  = 1'b1;
                        w_word_brk = 1'b1;
                        w_word_frm = 1'b0;
                    end else if (r_bit_cnt == c_stop_last) begin
                        w_deliver   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_os_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_zero     <= 1'b1;
            r_brk_hold <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_os_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_zero     <= 1'b1;
            r_brk_hold <= 1'b0;
        end else if (w_tick) begin
            r_os_cnt <= w_sample ? '0 : r_os_cnt + c_os_w'(1);
            if (w_sample) begin
                case (r_state)
                    ST_DATA: begin
                        r_shift   <= {r_sync2, r_shift[DATA_BITS-1:1]};
                        r_zero    <= r_zero & !r_sync2;
                        r_bit_cnt <= (r_bit_cnt == c_data_last) ? '0 : r_bit_cnt + c_bit_w'(1);
                    end
                    ST_PARITY: begin
                        r_par_err <= (r_sync2 != w_par_exp);
                        r_zero    <= r_zero & !r_sync2;
                    end
                    ST_STOP: begin
                        r_frm_err  <= r_frm_err | !r_sync2;
                        r_bit_cnt  <= r_bit_cnt + c_bit_w'(1);
                        r_brk_hold <= w_word_brk;
                    end
                    default: ;
                endcase
            end
        end
    end

    // A completed word is dropped only when the held word is not being taken.
    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (w_deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= r_shift;
                    parity_err <= r_par_err;
                    frame_err  <= w_word_frm;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_BREAK_EN
    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            break_det <= 1'b0;
        end else if (w_deliver && (!rx_valid || rx_ready)) begin
            break_det <= w_word_brk;
        end
    end
`endif

    assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire
